// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back versus a small FIFO of
// multi-cycle unit results. An aging counter forces a one-cycle drain slot.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_reg,
    input  logic [31:0] mc_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_pipe,
    input  logic [4:0]  hz_reg,
    output logic        hz_hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {S_NORMAL, S_FORCE} state_t;

    state_t          r_state;
    logic            r_valid [DEPTH];
    logic [4:0]      r_reg   [DEPTH];
    logic [31:0]     r_data  [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_starve;

    logic            w_head_present;
    logic            w_head_valid;
    logic            w_wb_req;
    logic            w_any_valid;
    logic            w_grant_wb;
    logic            w_grant_fifo;
    logic            w_pop;
    logic            w_push;
    logic            w_not_full;
    logic            w_hz_queued;
    logic [SW-1:0]   w_starve_next;
    state_t          w_state_next;

    assign w_head_present = (r_count != '0);
    assign w_head_valid   = r_valid[r_rd_ptr];
    assign w_wb_req       = wb_reg_write && (wb_write_reg != 5'd0);
    assign w_not_full     = (r_count < CW'(DEPTH));
    assign w_push         = mc_valid && w_not_full;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_grant_wb   = 1'b0;
        w_grant_fifo = 1'b0;
        if (r_state == S_FORCE) begin
            w_grant_fifo = w_head_present;
        end else if (w_wb_req) begin
            w_grant_wb = 1'b1;
        end else begin
            w_grant_fifo = w_head_present;
        end
    end

    // Killed (invalid) heads are discarded even when the port goes to WB.
    assign w_pop = w_grant_fifo || (w_head_present && !w_head_valid);

    // Popped slots have their valid bit cleared, so a flat scan is exact.
    always_comb begin
        w_any_valid = 1'b0;
        w_hz_queued = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                w_any_valid = 1'b1;
                if (r_reg[i] == hz_reg) w_hz_queued = 1'b1;
            end
        end
    end

    always_comb begin
        w_starve_next = r_starve;
        if (r_state == S_FORCE || w_grant_fifo || !w_any_valid) begin
            w_starve_next = '0;
        end else if (w_grant_wb && r_starve != SW'(STARVE_LIMIT)) begin
            w_starve_next = r_starve + 1'b1;
        end
        w_state_next = S_NORMAL;
        if (r_state == S_NORMAL && w_starve_next == SW'(STARVE_LIMIT)) begin
            w_state_next = S_FORCE;
        end
    end

    // Outputs are held quiet combinationally while reset is asserted.
    assign mc_ready   = rst_n && w_not_full;
    assign rf_we      = rst_n && (w_grant_wb || (w_grant_fifo && w_head_valid));
    assign rf_waddr   = w_grant_wb ? wb_write_reg  : r_reg[r_rd_ptr];
    assign rf_wdata   = w_grant_wb ? wb_write_data : r_data[r_rd_ptr];
    assign stall_pipe = (r_state == S_FORCE);
    assign hz_hit     = rst_n && (hz_reg != 5'd0) &&
                        (w_hz_queued || (mc_valid && mc_reg == hz_reg));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_NORMAL;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_next;
            r_starve <= w_starve_next;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The push write comes last so a same-cycle kill never hits the new entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_grant_wb && r_reg[i] == wb_write_reg) r_valid[i] <= 1'b0;
            end
            if (w_pop)  r_valid[r_rd_ptr] <= 1'b0;
            if (w_push) r_valid[r_wr_ptr] <= (mc_reg != 5'd0);
        end
    end

    // NOTE: only the valid bits need reset; payload is never observed while
    // its valid bit is clear, so the storage array stays reset-free.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg[r_wr_ptr]  <= mc_reg;
            r_data[r_wr_ptr] <= mc_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wb_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_write_reg = '0;
    logic [31:0] wb_write_data = '0;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_reg = '0;
    logic [31:0] mc_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_pipe;
    logic [4:0]  hz_reg = '0;
    logic        hz_hit;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_reg(mc_reg), .mc_data(mc_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_pipe(stall_pipe), .hz_reg(hz_reg), .hz_hit(hz_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         v;
        logic [4:0] r;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_force = 1'b0;
    int   m_starve = 0;

    // One cycle of the reference: expected outputs from the current inputs,
    // then the queue/aging state as it must look after the next rising edge.
    task automatic model_step();
        bit wb_req, gw, gf, any_v, pop, exp_hz, exp_we;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        int n;
        n = q.size();
        wb_req = wb_reg_write && wb_write_reg != 0;
        any_v = 0;
        exp_hz = 0;
        foreach (q[i]) begin
            if (q[i].v) begin
                any_v = 1;
                if (q[i].r == hz_reg) exp_hz = 1;
            end
        end
        if (mc_valid && mc_reg == hz_reg) exp_hz = 1;
        if (hz_reg == 0) exp_hz = 0;
        gw = 0;
        gf = 0;
        if (m_force)     gf = (n > 0);
        else if (wb_req) gw = 1;
        else             gf = (n > 0);
        exp_we = gw || (gf && q[0].v);
        exp_a = gw ? wb_write_reg  : (n > 0 ? q[0].r : 5'd0);
        exp_d = gw ? wb_write_data : (n > 0 ? q[0].d : 32'd0);

        check("m_rf_we", rf_we, exp_we);
        if (exp_we) begin
            check("m_rf_waddr", rf_waddr, exp_a);
            check("m_rf_wdata", rf_wdata, exp_d);
        end
        check("m_stall", stall_pipe, m_force);
        check("m_mc_ready", mc_ready, n < DEPTH);
        check("m_hz_hit", hz_hit, exp_hz);

        pop = gf || (n > 0 && !q[0].v);
        if (gw) foreach (q[i]) if (q[i].r == wb_write_reg) q[i].v = 0;
        if (pop) void'(q.pop_front());
        if (mc_valid && n < DEPTH) q.push_back('{v: mc_reg != 0, r: mc_reg, d: mc_data});
        if (m_force) begin
            m_force = 0;
            m_starve = 0;
        end else begin
            if (gf || !any_v)                  m_starve = 0;
            else if (gw && m_starve < LIMIT)   m_starve = m_starve + 1;
            if (m_starve == LIMIT) m_force = 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_force = 0;
            m_starve = 0;
            check("rst_rf_we", rf_we, 0);
            check("rst_stall", stall_pipe, 0);
            check("rst_mc_ready", mc_ready, 0);
            check("rst_hz_hit", hz_hit, 0);
        end else begin
            model_step();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                         input bit mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic [4:0] hz);
        wb_reg_write  = we;
        wb_write_reg  = wr;
        wb_write_data = wd;
        mc_valid      = mv;
        mc_reg        = mr;
        mc_data       = md;
        hz_reg        = hz;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
    endtask

    initial begin
        #3;
        check("lit_rst_mc_ready", mc_ready, 0);
        check("lit_rst_rf_we", rf_we, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #3 check("lit_ready_after_rst", mc_ready, 1);
        cyc();

        // Single mc result with WB idle: written the next cycle.
        drive(0, 0, 0, 1, 5, 32'h11, 5);
        #3 check("t1_push_hz", hz_hit, 1);
        check("t1_push_no_we", rf_we, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 5);
        #3 check("t1_we", rf_we, 1);
        check("t1_waddr", rf_waddr, 5);
        check("t1_wdata", rf_wdata, 32'h11);
        check("t1_hz_still_pending", hz_hit, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 5);
        #3 check("t1_drained_we", rf_we, 0);
        check("t1_drained_hz", hz_hit, 0);
        cyc();

        // Starvation: three WB wins, then a forced drain with WB re-presented.
        drive(1, 3, 32'h100, 1, 7, 32'hAA, 0);
        cyc();
        for (int k = 1; k <= 3; k++) begin
            drive(1, 3, 32'h100 + k, 0, 0, 0, 0);
            #3 check("t2_wb_stall", stall_pipe, 0);
            check("t2_wb_wdata", rf_wdata, 32'h100 + k);
            cyc();
        end
        drive(1, 3, 32'h104, 0, 0, 0, 0);
        #3 check("t2_force_stall", stall_pipe, 1);
        check("t2_force_waddr", rf_waddr, 7);
        check("t2_force_wdata", rf_wdata, 32'hAA);
        cyc();
        drive(1, 3, 32'h104, 0, 0, 0, 0);
        #3 check("t2_replay_stall", stall_pipe, 0);
        check("t2_replay_wdata", rf_wdata, 32'h104);
        cyc();
        idle(2);

        // Fill to DEPTH under continuous WB; the full cycle refuses a push.
        for (int k = 0; k <= 4; k++) begin
            drive(1, 3, 32'h200 + k, 1, 5'(10 + k), 32'h300 + k, 0);
            #3 if (k == 4) begin
                check("t3_full_ready", mc_ready, 0);
                check("t3_full_force", stall_pipe, 1);
            end
            cyc();
        end
        drive(1, 3, 32'h205, 0, 0, 0, 0);
        #3 check("t3_ready_back", mc_ready, 1);
        cyc();
        idle(6);

        // Kill: a younger WB write to r9 drops the queued r9 result.
        drive(1, 3, 32'h400, 1, 9, 32'h1, 9);
        cyc();
        drive(1, 9, 32'h2, 0, 0, 0, 9);
        #3 check("t4_hz_before_kill", hz_hit, 1);
        check("t4_wb_waddr", rf_waddr, 9);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 9);
        #3 check("t4_hz_after_kill", hz_hit, 0);
        check("t4_no_stale_we", rf_we, 0);
        cyc();
        idle(3);

        // r0 destinations never write and never hazard.
        drive(1, 0, 32'h55, 1, 0, 32'h66, 0);
        #3 check("t5_r0_we", rf_we, 0);
        check("t5_r0_hz", hz_hit, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        #3 check("t5_r0_drain_we", rf_we, 0);
        cyc();
        idle(2);

        // Mixed traffic, checked by the model every cycle.
        for (int i = 0; i < 40; i++) begin
            drive(i % 3 != 2, 5'(i % 6), 32'h800 + i,
                  (i % 4 == 1) || (i % 5 == 0), 5'((i * 7) % 8), 32'h900 + i, 5'(i % 8));
            cyc();
        end
        idle(8);

        // Reset during FORCE with three entries queued.
        for (int k = 0; k < 4; k++) begin
            drive(1, 3, 32'h600 + k, k < 3, 5'(20 + k), 32'h700 + k, 0);
            cyc();
        end
        drive(1, 3, 32'h604, 0, 0, 0, 21);
        #1 check("t6_in_force", stall_pipe, 1);
        check("t6_hz_queued", hz_hit, 1);
        rst_n = 1'b0;
        #1 check("t6_rst_stall", stall_pipe, 0);
        check("t6_rst_we", rf_we, 0);
        check("t6_rst_ready", mc_ready, 0);
        check("t6_rst_hz", hz_hit, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 21);
        #3 check("t6_post_ready", mc_ready, 1);
        check("t6_post_we", rf_we, 0);
        check("t6_post_hz", hz_hit, 0);
        cyc();
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
